dnn_infer_ctrl: RTL and testbench

Sequencer wrapped around the fixed-point ReLU inference engine (15-bit data, 17-bit address). Accepts an image as a valid/ready pixel stream and writes it into the activation region of the shared model memory. Then soft-resets and starts the engine, waits for done with a timeout, runs a sequential argmax over the 10 class scores, and presents one result per image on a valid/ready port.

---
 rtl/dnn_ctrl_pkg.sv | 23 ++
 rtl/dnn_argmax_seq.sv | 67 ++++++
 rtl/dnn_infer_ctrl.sv | 139 +++++++++++++
 tb/tb_dnn_infer_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_ctrl_pkg.sv
// Shared types and constants for the DNN inference sequencer.
//   ctrl_state_t : sequencer states (load image, clear engine, start, wait,
//                  argmax scan, present result)
//   ERR_CLASS    : class code reported when the engine times out
//   score_t      : signed fixed-point score / pixel word
package dnn_ctrl_pkg;

  localparam int SCORE_W = 15;

  localparam logic [3:0] ERR_CLASS = 4'hF;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_CLR    = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ARGMAX = 3'd4,
    ST_RESULT = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/dnn_argmax_seq.sv
// Sequential argmax over a captured score vector.
//   clk, rst : clock, synchronous active-high reset (control only)
//   load     : capture scores, seed best with element 0
//   scores   : packed score vector, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   done     : high during the cycle that performs the final compare
//   cls      : index of the winning score (valid after done)
//   score    : winning score (valid after done)
// One signed compare per cycle; update only on strictly greater, so ties
// resolve to the lowest index.
module dnn_argmax_seq
  import dnn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 15,
  parameter int NUM_CLASSES = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0]     scores,
  output logic                                  done,
  output logic [3:0]                            cls,
  output logic signed [DATA_WIDTH-1:0]          score
);

  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic signed [DATA_WIDTH-1:0] sbuf_p0 [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best_p0;
  logic [IDX_W-1:0]             bidx_p0;
  logic [IDX_W-1:0]             idx_p0;
  logic                         vld_p0;

  // Stage p0: capture vector, then scan index idx_p0 against running best
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        sbuf_p0[k] <= scores[k*DATA_WIDTH +: DATA_WIDTH];
      end
      best_p0 <= scores[DATA_WIDTH-1:0];
      bidx_p0 <= '0;
    end else if (vld_p0 && (sbuf_p0[idx_p0] > best_p0)) begin
      best_p0 <= sbuf_p0[idx_p0];
      bidx_p0 <= idx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      idx_p0 <= '0;
    end else if (load) begin
      vld_p0 <= 1'b1;
      idx_p0 <= IDX_W'(1);
    end else if (vld_p0) begin
      if (idx_p0 == IDX_W'(NUM_CLASSES-1)) begin
        vld_p0 <= 1'b0;
      end else begin
        idx_p0 <= idx_p0 + 1'b1;
      end
    end
  end

  assign done  = vld_p0 && (idx_p0 == IDX_W'(NUM_CLASSES-1));
  assign cls   = 4'(bidx_p0);
  assign score = best_p0;

endmodule

// File: rtl/dnn_infer_ctrl.sv
// Sequencer around the fixed-point ReLU inference engine.
//   clk, rst            : clock, synchronous active-high reset
//   pix_valid/ready/data: image pixel stream in
//   mem_wr_en/addr/data : writes pixels into the activation region
//   dnn_reset/start     : one-cycle engine soft reset and start
//   dnn_done, dnn_out   : engine completion level and packed class scores
//   res_valid/ready     : one result per image, held until consumed
//   res_class/score/err : argmax index and score, or ERR_CLASS/0/1 on timeout
//   img_count           : completed results, wrapping
module dnn_infer_ctrl
  import dnn_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 15,
  parameter int                    ADDR_WIDTH     = 17,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A    = '0,
  parameter int                    IMG_WORDS      = 400,
  parameter int                    NUM_CLASSES    = 10,
  parameter int                    TIMEOUT_CYCLES = 200000,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  input  logic signed [DATA_WIDTH-1:0]      pix_data,
  output logic                              mem_wr_en,
  output logic [ADDR_WIDTH-1:0]             mem_wr_addr,
  output logic signed [DATA_WIDTH-1:0]      mem_wr_data,
  output logic                              dnn_reset,
  output logic                              dnn_start,
  input  logic                              dnn_done,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] dnn_out,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [3:0]                        res_class,
  output logic signed [DATA_WIDTH-1:0]      res_score,
  output logic                              res_err,
  output logic [CNT_WIDTH-1:0]              img_count
);

  localparam int IDX_W = $clog2(IMG_WORDS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  ctrl_state_t                  state;
  logic [IDX_W-1:0]             idx;
  logic [TO_W-1:0]              to_cnt;
  logic                         err_q;
  logic [CNT_WIDTH-1:0]         count_q;

  logic                         pix_accept;
  logic                         am_load;
  logic                         am_done;
  logic [3:0]                   am_cls;
  logic signed [DATA_WIDTH-1:0] am_score;
  logic                         in_result;

  assign pix_accept = (state == ST_LOAD) && pix_valid;
  assign am_load    = (state == ST_WAIT) && dnn_done;
  assign in_result  = (state == ST_RESULT);

  // Writes are combinational from the accept so back-to-back pixels need no bubble
  always_comb begin
    pix_ready   = (state == ST_LOAD);
    mem_wr_en   = pix_accept;
    mem_wr_addr = ADDR_BASE_A + ADDR_WIDTH'(idx);
    mem_wr_data = pix_accept ? pix_data : '0;
    dnn_reset   = (state == ST_CLR);
    dnn_start   = (state == ST_START);
    res_valid   = in_result;
    res_err     = in_result && err_q;
    res_class   = in_result ? (err_q ? ERR_CLASS : am_cls) : 4'h0;
    res_score   = (in_result && !err_q) ? am_score : '0;
    img_count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LOAD;
      idx     <= '0;
      to_cnt  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (pix_accept) begin
            if (idx == IDX_W'(IMG_WORDS-1)) begin
              idx   <= '0;
              state <= ST_CLR;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_CLR: state <= ST_START;
        ST_START: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // done has priority over a coincident timeout
          if (dnn_done) begin
            err_q <= 1'b0;
            state <= ST_ARGMAX;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES-1)) begin
            err_q <= 1'b1;
            state <= ST_RESULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_ARGMAX: begin
          if (am_done) state <= ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready) begin
            count_q <= count_q + 1'b1;
            state   <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  dnn_argmax_seq #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CLASSES (NUM_CLASSES)
  ) u_argmax (
    .clk    (clk),
    .rst    (rst),
    .load   (am_load),
    .scores (dnn_out),
    .done   (am_done),
    .cls    (am_cls),
    .score  (am_score)
  );

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Self-checking bench for dnn_infer_ctrl: directed images, an engine model
// driving dnn_done/dnn_out, and a timeline-based reference checked every cycle.
module tb_dnn_infer_ctrl;
  import dnn_ctrl_pkg::*;

  localparam int DW  = 15;
  localparam int AW  = 17;
  localparam int NC  = 10;
  localparam int IMG = 400;
  localparam int TO  = 50;
  localparam int CW  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pix_valid;
  logic                  pix_ready;
  logic signed [DW-1:0]  pix_data;
  logic                  mem_wr_en;
  logic [AW-1:0]         mem_wr_addr;
  logic signed [DW-1:0]  mem_wr_data;
  logic                  dnn_reset;
  logic                  dnn_start;
  logic                  dnn_done;
  logic [NC*DW-1:0]      dnn_out;
  logic                  res_valid;
  logic                  res_ready;
  logic [3:0]            res_class;
  logic signed [DW-1:0]  res_score;
  logic                  res_err;
  logic [CW-1:0]         img_count;

  always #5 clk = ~clk;

  dnn_infer_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_BASE_A(17'h00000), .IMG_WORDS(IMG),
    .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .dnn_reset(dnn_reset), .dnn_start(dnn_start),
    .dnn_done(dnn_done), .dnn_out(dnn_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_class(res_class), .res_score(res_score),
    .res_err(res_err), .img_count(img_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- engine model ----------------
  score_t eng_sc [NC];
  int     eng_delay;

  function automatic logic [NC*DW-1:0] pack_scores();
    logic [NC*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = eng_sc[i];
    return v;
  endfunction

  initial begin : engine
    int   cnt;
    logic s, r;
    cnt      = -1;
    dnn_done = 1'b0;
    dnn_out  = '0;
    forever begin
      @(negedge clk);
      s = dnn_start;
      r = dnn_reset;
      @(posedge clk); #1;
      // scores change after done; the result must come from the done cycle
      if (dnn_done) dnn_out = {NC{15'h2AAA}};
      if (r) dnn_done = 1'b0;
      if (s) cnt = eng_delay;
      else if (cnt > 0) cnt--;
      if (cnt == 0) begin
        dnn_done = 1'b1;
        dnn_out  = pack_scores();
        cnt      = -1;
      end
    end
  end

  // ---------------- reference model ----------------
  // argmax = first index holding the maximum value
  function automatic void ref_argmax(input logic [NC*DW-1:0] v, output int cls, output int sc);
    score_t t;
    int     mx;
    t  = v[DW-1:0];
    mx = t;
    for (int i = 1; i < NC; i++) begin
      t = v[i*DW +: DW];
      if (int'(t) > mx) mx = t;
    end
    cls = -1;
    for (int i = NC-1; i >= 0; i--) begin
      t = v[i*DW +: DW];
      if (int'(t) == mx) cls = i;
    end
    sc = mx;
  endfunction

  bit m_started = 0, m_loading = 1, m_tl = 0, m_wait = 0, m_have = 0, m_prev_valid = 0;
  int m_idx = 0, m_tlast = 0, m_wfrom = 0, m_resat = 0, m_cnt = 0;
  int m_cls = 0, m_sc = 0;
  bit m_err = 0;
  int t_done_obs = 0, t_rise = 0, n_resets = 0, n_starts = 0;
  int last_wr_addr = 0, last_wr_data = 0;

  initial begin : compare
    int n;
    bit exp_wr, exp_valid;
    forever begin
      @(negedge clk);
      n = cyc;
      if (rst) begin
        m_started = 1; m_loading = 1; m_tl = 0; m_wait = 0; m_have = 0;
        m_idx = 0; m_cnt = 0; m_prev_valid = 0;
      end else if (m_started) begin
        exp_wr    = m_loading && pix_valid;
        exp_valid = m_have && (n >= m_resat);
        check("pix_ready", pix_ready, m_loading);
        check("mem_wr_en", mem_wr_en, exp_wr);
        if (exp_wr) begin
          check("mem_wr_addr", mem_wr_addr, m_idx);
          check("mem_wr_data", mem_wr_data, pix_data);
        end
        check("dnn_reset", dnn_reset, m_tl && (n == m_tlast + 1));
        check("dnn_start", dnn_start, m_tl && (n == m_tlast + 2));
        check("res_valid", res_valid, exp_valid);
        if (exp_valid) begin
          check("res_class", res_class, m_cls);
          check("res_score", res_score, m_sc);
          check("res_err", res_err, m_err);
        end
        check("img_count", img_count, m_cnt);

        if (dnn_reset) n_resets++;
        if (dnn_start) n_starts++;
        if (res_valid && !m_prev_valid) t_rise = n;
        m_prev_valid = res_valid;

        if (exp_wr) begin
          if (m_idx == IMG-1) begin
            last_wr_addr = mem_wr_addr;
            last_wr_data = mem_wr_data;
            m_loading = 0; m_tl = 1; m_tlast = n; m_idx = 0;
            m_wait = 1; m_wfrom = n + 3;
          end else begin
            m_idx++;
          end
        end
        if (m_wait && n >= m_wfrom) begin
          if (dnn_done) begin
            ref_argmax(dnn_out, m_cls, m_sc);
            m_err = 0; m_resat = n + 10; m_have = 1; m_wait = 0; t_done_obs = n;
          end else if (n - m_wfrom == TO - 1) begin
            m_err = 1; m_cls = 15; m_sc = 0; m_resat = n + 1; m_have = 1; m_wait = 0;
          end
        end
        if (exp_valid && res_ready) begin
          m_cnt = (m_cnt + 1) % 65536;
          m_have = 0; m_loading = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int n, input int base, input int step, input bit keep);
    int k, guard;
    k = 0; guard = 0;
    while (k < n && guard < 4*n + 100) begin
      pix_valid = 1'b1;
      pix_data  = DW'(base + k*step);
      @(negedge clk);
      if (pix_ready) k++;
      guard++;
      @(posedge clk); #1;
    end
    if (k < n) check("send_accepts", k, n);
    pix_valid = keep;
  endtask

  task automatic wait_valid(input int maxc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_valid && k < maxc);
    if (!res_valid) check("res_valid_wait", 0, 1);
    #2;
  endtask

  task automatic set_scores(input int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9);
    eng_sc[0] = DW'(s0); eng_sc[1] = DW'(s1); eng_sc[2] = DW'(s2); eng_sc[3] = DW'(s3);
    eng_sc[4] = DW'(s4); eng_sc[5] = DW'(s5); eng_sc[6] = DW'(s6); eng_sc[7] = DW'(s7);
    eng_sc[8] = DW'(s8); eng_sc[9] = DW'(s9);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] c0;
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; res_ready = 1'b1; eng_delay = -1;
    set_scores(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_pix_ready", pix_ready, 1);
    check("reset_img_count", img_count, 0);
    check("reset_mem_wr_en", mem_wr_en, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_dnn_reset", dnn_reset, 0);
    @(posedge clk); #1;

    // A: ramp image, tie between 2 and 4 resolves to 2
    eng_delay = 3;
    set_scores(5, -3, 100, 7, 100, 0, -16384, 2, 99, 1);
    send(IMG, 0, 1, 1'b0);
    wait_valid(200);
    check("A_class", res_class, 2);
    check("A_score", res_score, 100);
    check("A_err", res_err, 0);
    check("A_last_addr", last_wr_addr, 17'h18F);
    check("A_last_data", last_wr_data, 399);
    check("A_done_latency", t_done_obs - m_tlast, 6);
    check("A_valid_latency", t_rise - t_done_obs, 10);
    @(posedge clk); #1;
    @(negedge clk);
    check("A_img_count", img_count, 1);
    check("A_pix_ready", pix_ready, 1);
    @(posedge clk); #1;

    // B: all negative, only the last class is the maximum
    eng_delay = 1;
    set_scores(-200, -200, -200, -200, -200, -200, -200, -200, -200, -1);
    send(IMG, -200, 1, 1'b0);
    wait_valid(200);
    check("B_class", res_class, 9);
    check("B_score", res_score, -1);
    @(posedge clk); #1;

    // C: engine never finishes
    eng_delay = -1;
    send(IMG, 5, 3, 1'b0);
    wait_valid(200);
    check("C_err", res_err, 1);
    check("C_class", res_class, 15);
    check("C_score", res_score, 0);
    check("C_latency", t_rise - m_tlast, 53);
    @(posedge clk); #1;

    // D: result back-pressure with pixels pending
    res_ready = 1'b0;
    eng_delay = 0;
    set_scores(42, 42, 42, 42, 42, 42, 42, 42, 42, 42);
    send(IMG, 1000, -2, 1'b1);
    wait_valid(200);
    c0 = res_class;
    repeat (20) @(negedge clk);
    check("D_held_valid", res_valid, 1);
    check("D_held_class", res_class, c0);
    check("D_class", res_class, 0);
    check("D_score", res_score, 42);
    check("D_pix_ready", pix_ready, 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    check("D_img_count", img_count, 4);
    check("D_pix_ready_after", pix_ready, 1);
    @(posedge clk); #1;

    // E: reset mid-image, then a full image
    send(123, 7, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("E_img_count_reset", img_count, 0);
    check("E_pix_ready_reset", pix_ready, 1);
    @(posedge clk); #1;
    eng_delay = 5;
    set_scores(-5, 0, 3, 3, 12, -100, 12, 11, 4, 12);
    send(IMG, 300, 5, 1'b0);
    wait_valid(200);
    check("E_class", res_class, 4);
    check("E_score", res_score, 12);
    @(posedge clk); #1;
    @(negedge clk);
    check("E_img_count", img_count, 1);
    check("E_reset_pulses", n_resets, 5);
    check("E_start_pulses", n_starts, 5);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
